// File: rtl/ssd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl_if
// Description : Value-load handshake and display-drive bundle between a value
//               source, the 4-digit scan controller and the bin2ssd decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface ssd_scan_ctrl_if;
    logic [9:0] value;   // unsigned binary value to display
    logic       load;    // request a conversion of value
    logic       busy;    // conversion in progress
    logic       done;    // one-cycle pulse when new digits are installed
    logic [3:0] nibble;  // BCD digit of the current scan slot
    logic       blank;   // current slot is blanked
    logic [3:0] an;      // digit enables, an[0] = units

    // Value source side
    modport master (
        output value, load,
        input  busy, done, nibble, blank, an
    );

    // Scan controller side
    modport slave (
        input  value, load,
        output busy, done, nibble, blank, an
    );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : 4-digit multiplexed 7-segment controller. A sequential
//               double-dabble engine converts a 10-bit value to BCD; a free
//               running scanner presents one digit per slot with optional
//               leading-zero blanking.
// Revision    : 1.0  initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter bit AN_ACT_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ssd_scan_ctrl_if.slave bus
);

    localparam int                c_CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        c_AN_OFF   = AN_ACT_LOW ? 4'hF : 4'h0;
    localparam logic [3:0]        c_ITER_END = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [9:0]          r_bin;
    logic [15:0]         r_bcd;
    logic [15:0]         w_bcd_adj;
    logic [3:0]          r_iter;
    logic [15:0]         r_digits;
    logic [15:0]         w_digits_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_next;
    logic [3:0]          w_lz;
    logic                w_blank_next;
    logic [3:0]          w_an_onehot;
    logic [3:0]          r_nibble;
    logic                r_blank;
    logic [3:0]          r_an;

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Conversion FSM next state: ten shift iterations then one install cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.load) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (r_iter == c_ITER_END) w_state_next = ST_FINISH;
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Double-dabble datapath: capture on accepted load, shift while in SHIFT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_bin  <= bus.value;
                        r_bcd  <= '0;
                        r_iter <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd  <= {w_bcd_adj[14:0], r_bin[9]};
                    r_bin  <= {r_bin[8:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Next scan position and next display digits; the output registers are
    // loaded from these so a new result and a slot change both appear on the
    // very edge that produces them.
    always_comb begin
        w_digits_next = (r_state == ST_FINISH) ? r_bcd : r_digits;
        if (r_cnt == c_CNT_LAST) begin
            w_cnt_next = '0;
            w_idx_next = r_idx + 2'd1;
        end else begin
            w_cnt_next = r_cnt + c_CNT_W'(1);
            w_idx_next = r_idx;
        end
        // w_lz[i]: digit i and every more-significant digit are zero
        w_lz[3] = (w_digits_next[15:12] == 4'd0);
        w_lz[2] = (w_digits_next[11:8]  == 4'd0) && w_lz[3];
        w_lz[1] = (w_digits_next[7:4]   == 4'd0) && w_lz[2];
        w_lz[0] = (w_digits_next[3:0]   == 4'd0) && w_lz[1];
        w_blank_next = BLANK_LZ && (w_idx_next != 2'd0) && w_lz[w_idx_next];
        w_an_onehot  = w_blank_next ? 4'b0000 : (4'b0001 << w_idx_next);
    end

    // Scan counter, display digits and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_digits <= '0;
            r_nibble <= '0;
            r_blank  <= 1'b1;
            r_an     <= c_AN_OFF;
        end else begin
            r_cnt    <= w_cnt_next;
            r_idx    <= w_idx_next;
            r_digits <= w_digits_next;
            r_nibble <= w_digits_next[w_idx_next*4 +: 4];
            r_blank  <= w_blank_next;
            r_an     <= AN_ACT_LOW ? ~w_an_onehot : w_an_onehot;
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_FINISH);
    assign bus.nibble = r_nibble;
    assign bus.blank  = r_blank;
    assign bus.an     = r_an;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Directed bench for ssd_scan_ctrl; one instance with leading-
//               zero blanking, one without, both active-low enables.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ssd_scan_ctrl;

    localparam int SD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] value = '0;
    logic       load  = 1'b0;

    int passed  = 0;
    int total   = 0;
    int model_k = 0;   // edges since reset release; slot = (model_k/SD)%4

    always #5 clk = ~clk;

    ssd_scan_ctrl_if ifa ();
    ssd_scan_ctrl_if ifb ();

    assign ifa.value = value;
    assign ifa.load  = load;
    assign ifb.value = value;
    assign ifb.load  = load;

    ssd_scan_ctrl #(.SCAN_DIV(SD), .AN_ACT_LOW(1'b1), .BLANK_LZ(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    ssd_scan_ctrl #(.SCAN_DIV(SD), .AN_ACT_LOW(1'b1), .BLANK_LZ(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    // Reference scan position
    always @(posedge clk) model_k <= rst_n ? model_k + 1 : 0;

    typedef struct {
        logic [9:0]  value;
        logic [15:0] bcd;    // expected d3..d0
        logic [3:0]  mask;   // expected blanked slots with leading-zero blanking
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [9:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("busy_after_load", int'(ifa.busy), 1);
    endtask

    // Waits (bounded) for done, then checks the install edge
    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (!ifa.done && n < 40) begin
            tick();
            n++;
        end
        chk("done_latency", n, exp_lat);
        chk("done_b", int'(ifb.done), 1);
        chk("busy_at_done", int'(ifa.busy), 1);
        tick();
        chk("busy_after_finish", int'(ifa.busy), 0);
        chk("done_single_cycle", int'(ifa.done), 0);
    endtask

    // Observes the scan over several cycles against the reference slot
    task automatic show(input logic [15:0] bcd, input logic [3:0] mask, input int cycles);
        int         idx;
        logic [3:0] dig;
        logic [3:0] exp_an;
        logic [3:0] exp_an_b;
        for (int c = 0; c < cycles; c++) begin
            idx      = (model_k / SD) % 4;
            dig      = bcd[idx*4 +: 4];
            exp_an_b = ~(4'b0001 << idx);
            exp_an   = mask[idx] ? 4'hF : exp_an_b;
            chk("nibble_a", int'(ifa.nibble), int'(dig));
            chk("an_a",     int'(ifa.an),     int'(exp_an));
            chk("blank_a",  int'(ifa.blank),  int'(mask[idx]));
            chk("nibble_b", int'(ifb.nibble), int'(dig));
            chk("an_b",     int'(ifb.an),     int'(exp_an_b));
            chk("blank_b",  int'(ifb.blank),  0);
            chk("no_done",  int'(ifa.done),   0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{10'd1023, 16'h1023, 4'b0000};
        vecs[1] = '{10'd7,    16'h0007, 4'b1110};
        vecs[2] = '{10'd0,    16'h0000, 4'b1110};
        vecs[3] = '{10'd42,   16'h0042, 4'b1100};
        vecs[4] = '{10'd999,  16'h0999, 4'b1000};
        vecs[5] = '{10'd1000, 16'h1000, 4'b0000};
        vecs[6] = '{10'd10,   16'h0010, 4'b1100};
        vecs[7] = '{10'd5,    16'h0005, 4'b1110};
        vecs[8] = '{10'd509,  16'h0509, 4'b1000};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy",   int'(ifa.busy),   0);
        chk("rst_done",   int'(ifa.done),   0);
        chk("rst_an",     int'(ifa.an),     15);
        chk("rst_blank",  int'(ifa.blank),  1);
        chk("rst_nibble", int'(ifa.nibble), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_an",     int'(ifa.an),     14);
        chk("rel_blank",  int'(ifa.blank),  0);
        chk("rel_nibble", int'(ifa.nibble), 0);
        show(16'h0000, 4'b1110, 2 * 4 * SD);

        // Table-driven conversions
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].value);
            wait_done(10);
            show(vecs[i].bcd, vecs[i].mask, 4 * SD + 3);
        end

        // Load while busy is ignored; value changes during busy have no effect
        do_load(10'd100);
        tick();
        tick();
        value = 10'd5;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("busy_ignored_load", int'(ifa.busy), 1);
        wait_done(7);
        show(16'h0100, 4'b1000, 5 * SD);

        // Display holds old digits during a conversion
        do_load(10'd7);
        show(16'h0100, 4'b1000, 8);
        wait_done(2);
        show(16'h0007, 4'b1110, 4 * SD);

        // Reset mid-conversion aborts without a done pulse
        do_load(10'd999);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy",   int'(ifa.busy),   0);
        chk("abort_done",   int'(ifa.done),   0);
        chk("abort_an",     int'(ifa.an),     15);
        chk("abort_blank",  int'(ifa.blank),  1);
        rst_n = 1'b1;
        tick();
        show(16'h0000, 4'b1110, 4 * SD + 1);
        do_load(10'd42);
        wait_done(10);
        show(16'h0042, 4'b1100, 4 * SD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
